keypad_scan_encoder: RTL and testbench

- Scans a 4x4 matrix keypad, debounces it, and encodes the pressed key as a 4-bit hex code.
- Its key_code output is the nibble fed to the 7-segment decoder that drives the display.
- Sits between the keypad pins and the display path. One clock domain; synchronous, active-high reset.

---
 rtl/keypad_scan_encoder_pkg.sv | 32 +++
 rtl/keypad_scan_encoder_if.sv | 29 ++
 rtl/keypad_scan_encoder_tick_gen.sv | 35 +++
 rtl/keypad_scan_encoder.sv | 177 +++++++++++++++++
 tb/tb_keypad_scan_encoder.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/keypad_scan_encoder_pkg.sv
// ============================================================================
// Module   : keypad_pkg
// Purpose  : Shared types and constants for the 4x4 keypad scan encoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package keypad_pkg;

    localparam int KEY_ROWS   = 4;
    localparam int KEY_COLS   = 4;
    localparam int KEY_CODE_W = 4;

    localparam logic [KEY_COLS-1:0] c_col_reset = 4'b1110;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    // Index of the lowest-numbered active-low row; 0 when none is low.
    function automatic logic [1:0] lowest_low(input logic [KEY_ROWS-1:0] rows);
        lowest_low = 2'd0;
        for (int i = KEY_ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) lowest_low = i[1:0];
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_scan_encoder_if.sv
// ============================================================================
// Module   : keypad_scan_encoder_if
// Purpose  : Keypad pin and encoded-key signal bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface keypad_scan_encoder_if;
    import keypad_pkg::*;

    logic [KEY_ROWS-1:0]   key_row;
    logic [KEY_COLS-1:0]   key_col;
    logic [KEY_CODE_W-1:0] key_code;
    logic                  key_valid;
    logic                  key_pressed;

    modport master (
        input  key_row,
        output key_col, key_code, key_valid, key_pressed
    );

    modport slave (
        output key_row,
        input  key_col, key_code, key_valid, key_pressed
    );

endinterface

`default_nettype wire

// File: rtl/keypad_scan_encoder_tick_gen.sv
// ============================================================================
// Module   : keypad_tick_gen
// Purpose  : Free-running 0..COL_DWELL-1 counter; o_sample_tick marks the last count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_tick_gen #(
    parameter int COL_DWELL = 50000
) (
    input  wire logic clk,
    input  wire logic rst,
    output logic      o_sample_tick
);

    localparam int c_cnt_w = (COL_DWELL > 1) ? $clog2(COL_DWELL) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(COL_DWELL - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_sample_tick = (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/keypad_scan_encoder.sv
// ============================================================================
// Module   : keypad_scan_encoder
// Purpose  : Scans, debounces and hex-encodes a 4x4 active-low keypad.
//            Optional auto-repeat under macro KEYPAD_REPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_scan_encoder
    import keypad_pkg::*;
#(
    parameter int COL_DWELL    = 50000,
    parameter int DEBOUNCE_CNT = 16,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  wire logic             clk,
    input  wire logic             rst,
    keypad_scan_encoder_if.master kp
);

    localparam int c_db_w = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [c_db_w-1:0] c_db_target = c_db_w'(DEBOUNCE_CNT);

    logic [KEY_ROWS-1:0]   r_row_meta;
    logic [KEY_ROWS-1:0]   r_row_s;
    logic                  w_sample_tick;
    state_t                r_state;
    logic [1:0]            r_col_idx;
    logic [1:0]            r_row_idx;
    logic [KEY_COLS-1:0]   r_key_col;
    logic [KEY_CODE_W-1:0] r_key_code;
    logic                  r_key_valid;
    logic                  r_key_pressed;
    logic [c_db_w-1:0]     r_match;
    logic [c_db_w-1:0]     r_release;
    logic                  w_row_low;
    logic [1:0]            w_low_row;
    logic [KEY_COLS-1:0]   w_key_col_rot;

`ifdef KEYPAD_REPEAT_EN
    localparam int c_rp_max = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_rp_w   = $clog2(c_rp_max + 1);
    localparam logic [c_rp_w-1:0] c_delay = c_rp_w'(REPEAT_DELAY);
    localparam logic [c_rp_w-1:0] c_rate  = c_rp_w'(REPEAT_RATE);

    logic [c_rp_w-1:0] r_held;
    logic              r_repeating;
    logic [c_rp_w-1:0] w_held_nxt;
    assign w_held_nxt = r_held + 1'b1;
`else
    localparam int c_unused_repeat = REPEAT_DELAY + REPEAT_RATE;
`endif

    keypad_tick_gen #(
        .COL_DWELL (COL_DWELL)
    ) u_tick_gen (
        .clk           (clk),
        .rst           (rst),
        .o_sample_tick (w_sample_tick)
    );

    assign w_row_low     = ~r_row_s[r_row_idx];
    assign w_low_row     = lowest_low(r_row_s);
    assign w_key_col_rot = {r_key_col[KEY_COLS-2:0], r_key_col[KEY_COLS-1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_meta    <= '1;
            r_row_s       <= '1;
            r_state       <= SCAN;
            r_col_idx     <= 2'd0;
            r_row_idx     <= 2'd0;
            r_key_col     <= c_col_reset;
            r_key_code    <= '0;
            r_key_valid   <= 1'b0;
            r_key_pressed <= 1'b0;
            r_match       <= '0;
            r_release     <= '0;
`ifdef KEYPAD_REPEAT_EN
            r_held        <= '0;
            r_repeating   <= 1'b0;
`endif
        end else begin
            r_row_meta  <= kp.key_row;
            r_row_s     <= r_row_meta;
            r_key_valid <= 1'b0;

            case (r_state)
                SCAN: begin
                    if (w_sample_tick) begin
                        if (&r_row_s) begin
                            r_key_col <= w_key_col_rot;
                            r_col_idx <= r_col_idx + 1'b1;
                        end else begin
                            r_row_idx <= w_low_row;
                            // A single required sample means the capture tick is the accept tick.
                            if (DEBOUNCE_CNT <= 1) begin
                                r_key_code    <= {w_low_row, r_col_idx};
                                r_key_valid   <= 1'b1;
                                r_key_pressed <= 1'b1;
                                r_match       <= '0;
                                r_state       <= HELD;
                            end else begin
                                r_match <= c_db_w'(1);
                                r_state <= DEBOUNCE;
                            end
                        end
                    end
                end

                DEBOUNCE: begin
                    if (w_sample_tick) begin
                        if (w_row_low) begin
                            if (r_match + 1'b1 == c_db_target) begin
                                r_key_code    <= {r_row_idx, r_col_idx};
                                r_key_valid   <= 1'b1;
                                r_key_pressed <= 1'b1;
                                r_match       <= '0;
                                r_state       <= HELD;
                            end else begin
                                r_match <= r_match + 1'b1;
                            end
                        end else begin
                            r_match   <= '0;
                            r_key_col <= w_key_col_rot;
                            r_col_idx <= r_col_idx + 1'b1;
                            r_state   <= SCAN;
                        end
                    end
                end

                HELD: begin
                    if (w_sample_tick) begin
                        if (!w_row_low) begin
`ifdef KEYPAD_REPEAT_EN
                            r_held      <= '0;
                            r_repeating <= 1'b0;
`endif
                            if (r_release + 1'b1 == c_db_target) begin
                                r_release     <= '0;
                                r_key_pressed <= 1'b0;
                                r_key_col     <= w_key_col_rot;
                                r_col_idx     <= r_col_idx + 1'b1;
                                r_state       <= SCAN;
                            end else begin
                                r_release <= r_release + 1'b1;
                            end
                        end else begin
                            r_release <= '0;
`ifdef KEYPAD_REPEAT_EN
                            // First interval is REPEAT_DELAY, later ones REPEAT_RATE.
                            if (w_held_nxt == (r_repeating ? c_rate : c_delay)) begin
                                r_key_valid <= 1'b1;
                                r_held      <= '0;
                                r_repeating <= 1'b1;
                            end else begin
                                r_held <= w_held_nxt;
                            end
`endif
                        end
                    end
                end

                default: r_state <= SCAN;
            endcase
        end
    end

    assign kp.key_col     = r_key_col;
    assign kp.key_code    = r_key_code;
    assign kp.key_valid   = r_key_valid;
    assign kp.key_pressed = r_key_pressed;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scan_encoder.sv
// ============================================================================
// Module   : tb_keypad_scan_encoder
// Purpose  : Directed self-checking bench for keypad_scan_encoder with a keypad matrix model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_scan_encoder;
    import keypad_pkg::*;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic [15:0] keys = '0;   // bit r*4+c set = key at row r, column c pressed
    int          n_cmp   = 0;
    int          n_bad   = 0;
    int          n_valid = 0;
    int          n0;
    bit          ok;

    always #5 clk = ~clk;

    keypad_scan_encoder_if kp ();

    keypad_scan_encoder #(
        .COL_DWELL    (8),
        .DEBOUNCE_CNT (3),
        .REPEAT_DELAY (4),
        .REPEAT_RATE  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    // A row reads low only while a pressed key sits in the currently driven column.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            kp.key_row[r] = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && (kp.key_col[c] == 1'b0)) kp.key_row[r] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (kp.key_valid === 1'b1) n_valid <= n_valid + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (kp.key_valid === 1'b1) found = 1'b1;
        end
    endtask

    task automatic wait_col(input logic [3:0] exp, input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (kp.key_col === exp) found = 1'b1;
        end
    endtask

    task automatic wait_release(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (kp.key_pressed === 1'b0) found = 1'b1;
        end
    endtask

    initial begin
        // Reset and column rotation
        repeat (2) @(negedge clk);
        chk("rst_col", kp.key_col, 4'b1110);
        chk("rst_code", kp.key_code, 4'h0);
        chk("rst_valid", kp.key_valid, 1'b0);
        chk("rst_pressed", kp.key_pressed, 1'b0);
        rst = 1'b0;
        repeat (7) @(negedge clk);
        chk("dwell_col0", kp.key_col, 4'b1110);
        @(negedge clk);
        chk("dwell_col1", kp.key_col, 4'b1101);

        // Clean press row1/col2
        keys = 16'h0040;
        wait_col(4'b1011, 20, ok);
        chk("press_reach_col2", ok, 1'b1);
        wait_valid(60, ok);
        chk("press_valid_seen", ok, 1'b1);
        chk("press_code", kp.key_code, 4'h6);
        chk("press_pressed", kp.key_pressed, 1'b1);
        chk("press_col_frozen", kp.key_col, 4'b1011);
        n0 = n_valid;
        @(negedge clk);
        chk("press_valid_one_cycle", kp.key_valid, 1'b0);
        repeat (83) @(negedge clk);
`ifdef KEYPAD_REPEAT_EN
        chk("repeat_pulse_count", n_valid - n0, 5);
`else
        chk("press_single_valid", n_valid - n0, 1);
`endif
        chk("press_code_hold", kp.key_code, 4'h6);
        keys = '0;
        wait_release(60, ok);
        chk("release_seen", ok, 1'b1);
        chk("release_col3", kp.key_col, 4'b0111);
        chk("release_code_kept", kp.key_code, 4'h6);

        // Two keys in col1, rows 0 and 3
        keys = 16'h2002;
        wait_valid(80, ok);
        chk("two_valid_seen", ok, 1'b1);
        chk("two_code", kp.key_code, 4'h1);
        n0 = n_valid;
        repeat (30) @(negedge clk);
        chk("two_single_valid", n_valid - n0, 1);
        keys = '0;
        wait_release(60, ok);
        chk("two_release_seen", ok, 1'b1);
        chk("two_release_col2", kp.key_col, 4'b1011);

        // Bounce: row0/col3 low on capture tick, high on the next
        keys = 16'h0008;
        wait_col(4'b0111, 20, ok);
        chk("bounce_reach_col3", ok, 1'b1);
        n0 = n_valid;
        repeat (8) @(negedge clk);
        chk("bounce_capture_freeze", kp.key_col, 4'b0111);
        keys = '0;
        repeat (10) @(negedge clk);
        chk("bounce_col_advance", kp.key_col, 4'b1110);
        chk("bounce_no_valid", n_valid - n0, 0);
        chk("bounce_code_kept", kp.key_code, 4'h1);
        chk("bounce_not_pressed", kp.key_pressed, 1'b0);

        // Reset while HELD, then re-acceptance of the same key (row2/col3)
        keys = 16'h0800;
        wait_valid(100, ok);
        chk("held_valid_seen", ok, 1'b1);
        chk("held_code", kp.key_code, 4'hB);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("held_rst_col", kp.key_col, 4'b1110);
        chk("held_rst_code", kp.key_code, 4'h0);
        chk("held_rst_valid", kp.key_valid, 1'b0);
        chk("held_rst_pressed", kp.key_pressed, 1'b0);
        rst = 1'b0;
        wait_valid(150, ok);
        chk("repress_valid_seen", ok, 1'b1);
        chk("repress_code", kp.key_code, 4'hB);
        chk("repress_pressed", kp.key_pressed, 1'b1);
        keys = '0;
        wait_release(60, ok);
        chk("repress_release_seen", ok, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
